// File: rtl/qpsk_pkg.sv
// Shared constants for the square-wave QPSK link: carrier period, reference
// phase patterns and the Gray map between dibits and phase index.
package qpsk_pkg;

  localparam int CARR_PER = 4;

  // Bit n of each pattern is the carrier level at phase n.
  localparam logic [3:0] PAT_00 = 4'b0011;  //   0 deg: 1,1,0,0
  localparam logic [3:0] PAT_01 = 4'b0110;  //  90 deg: 0,1,1,0
  localparam logic [3:0] PAT_11 = 4'b1100;  // 180 deg: 0,0,1,1
  localparam logic [3:0] PAT_10 = 4'b1001;  // 270 deg: 1,0,0,1

  localparam logic [1:0] DIBIT_PH0 = 2'b00;
  localparam logic [1:0] DIBIT_PH1 = 2'b01;
  localparam logic [1:0] DIBIT_PH2 = 2'b11;
  localparam logic [1:0] DIBIT_PH3 = 2'b10;

  function automatic logic [3:0] ref_pat(input logic [1:0] idx);
    case (idx)
      2'd0:    return PAT_00;
      2'd1:    return PAT_01;
      2'd2:    return PAT_11;
      default: return PAT_10;
    endcase
  endfunction

  function automatic logic [1:0] idx_to_dibit(input logic [1:0] idx);
    case (idx)
      2'd0:    return DIBIT_PH0;
      2'd1:    return DIBIT_PH1;
      2'd2:    return DIBIT_PH2;
      default: return DIBIT_PH3;
    endcase
  endfunction

endpackage

// File: rtl/qpsk_corr.sv
// Four-phase correlator: per-phase match accumulators and a per-symbol
// maximum-match decision with fixed tie priority 00 > 01 > 11 > 10.
module qpsk_corr
  import qpsk_pkg::*;
#(
  parameter int SYM_LEN  = 8,
  parameter int MATCH_TH = 6,
  parameter int ACC_W    = $clog2(SYM_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [1:0] ph,
  input  logic       last,
  output logic [1:0] dibit,
  output logic       err,
  output logic       done
);

  logic [ACC_W-1:0] acc_q [4];
  logic [ACC_W-1:0] tot_d [4];
  logic [ACC_W-1:0] best_d;
  logic [1:0]       best_idx_d;
  logic [1:0]       dibit_q;
  logic             err_q;
  logic             done_q;

  function automatic logic ref_bit(input logic [1:0] idx, input logic [1:0] p);
    logic [3:0] w;
    w = ref_pat(idx);
    return w[p];
  endfunction

  // Totals include the current sample so the final sample of a symbol counts.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      tot_d[k] = acc_q[k] + ACC_W'(din == ref_bit(2'(k), ph));
    end
    best_d     = tot_d[0];
    best_idx_d = 2'd0;
    for (int k = 1; k < 4; k++) begin
      if (tot_d[k] > best_d) begin
        best_d     = tot_d[k];
        best_idx_d = 2'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) acc_q[k] <= '0;
      dibit_q <= 2'b00;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      for (int k = 0; k < 4; k++) acc_q[k] <= last ? '0 : tot_d[k];
      if (last) begin
        dibit_q <= idx_to_dibit(best_idx_d);
        err_q   <= (best_d < ACC_W'(MATCH_TH));
      end
    end
  end

  assign dibit = dibit_q;
  assign err   = err_q;
  assign done  = done_q;

endmodule

// File: rtl/qpsk_demod.sv
// QPSK square-wave demodulator: free-running phase/symbol counters aligned to
// the modulator's reset release, correlator decision and dibit serializer.
module qpsk_demod
  import qpsk_pkg::*;
#(
  parameter int SYM_LEN  = 8,
  parameter int MATCH_TH = 6,
  parameter int ACC_W    = $clog2(SYM_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [1:0] dibit,
  output logic       dibit_valid,
  output logic       sym_err,
  output logic       dout,
  output logic       dout_valid
);

  localparam int PH_W = $clog2(CARR_PER);
  localparam int S_W  = $clog2(SYM_LEN);

  logic [PH_W-1:0] ph_q, ph_d;
  logic [S_W-1:0]  s_q, s_d;
  logic            last;
  logic            dout_valid_q;
  logic [1:0]      dec_dibit;
  logic            dec_err;
  logic            dec_done;

  assign last = (s_q == S_W'(SYM_LEN - 1));

  always_comb begin
    ph_d = ph_q + PH_W'(1);
    s_d  = last ? '0 : s_q + S_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q         <= '0;
      s_q          <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
      s_q  <= s_d;
      if (last) dout_valid_q <= 1'b1;
    end
  end

  qpsk_corr #(
    .SYM_LEN  (SYM_LEN),
    .MATCH_TH (MATCH_TH),
    .ACC_W    (ACC_W)
  ) u_corr (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .ph    (ph_q),
    .last  (last),
    .dibit (dec_dibit),
    .err   (dec_err),
    .done  (dec_done)
  );

  assign dibit       = dec_dibit;
  assign dibit_valid = dec_done;
  assign sym_err     = dec_err;
  assign dout_valid  = dout_valid_q;

  // The held decision is the serializer's shift data; s restarts at each
  // decision, so the first half-symbol carries the MSB.
  assign dout = dout_valid_q & ((s_q < S_W'(SYM_LEN / 2)) ? dec_dibit[1] : dec_dibit[0]);

endmodule

// File: tb/tb_qpsk_demod.sv
// Directed testbench for qpsk_demod with hand-computed expectations.
module tb_qpsk_demod;

  logic       clk;
  logic       rst;
  logic       din;
  logic [1:0] dibit;
  logic       dibit_valid;
  logic       sym_err;
  logic       dout;
  logic       dout_valid;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  bit log_en   = 0;
  bit err_seen = 0;
  logic dout_log[$];

  localparam logic [3:0] T00 = 4'b0011;
  localparam logic [3:0] T01 = 4'b0110;
  localparam logic [3:0] T11 = 4'b1100;
  localparam logic [3:0] T10 = 4'b1001;

  qpsk_demod dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .dibit       (dibit),
    .dibit_valid (dibit_valid),
    .sym_err     (sym_err),
    .dout        (dout),
    .dout_valid  (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d);
    din = d;
    @(posedge clk);
    #1;
    if (log_en && dout_valid) dout_log.push_back(dout);
    if (dibit_valid) pulses++;
    if (sym_err) err_seen = 1;
  endtask

  task automatic send_sym(input logic [3:0] pat, input logic [7:0] flip);
    for (int i = 0; i < 8; i++) step(pat[i % 4] ^ flip[i]);
  endtask

  function automatic logic [3:0] pat_of(input logic [1:0] d);
    case (d)
      2'b00:   return T00;
      2'b01:   return T01;
      2'b11:   return T11;
      default: return T10;
    endcase
  endfunction

  initial begin
    logic [7:0] seq;
    logic [5:0] x;
    logic [3:0] p;
    logic [7:0] fl;
    rst = 1'b1;
    din = 1'b0;
    repeat (3) step(1'b0);
    chk("rst_dibit", {6'd0, dibit}, 8'h00);
    chk("rst_dibit_valid", {7'd0, dibit_valid}, 8'h00);
    chk("rst_sym_err", {7'd0, sym_err}, 8'h00);
    chk("rst_dout", {7'd0, dout}, 8'h00);
    chk("rst_dout_valid", {7'd0, dout_valid}, 8'h00);

    // First symbol: decision visible in cycle 8 only
    rst = 1'b0; log_en = 1; pulses = 0;
    for (int i = 0; i < 7; i++) step(T00[i % 4]);
    chk("early_valid", {7'd0, dibit_valid}, 8'h00);
    chk("early_dout_valid", {7'd0, dout_valid}, 8'h00);
    step(T00[3]);
    chk("s1_valid", {7'd0, dibit_valid}, 8'h01);
    chk("s1_dibit", {6'd0, dibit}, 8'h00);
    chk("s1_err", {7'd0, sym_err}, 8'h00);
    chk("s1_dout_valid", {7'd0, dout_valid}, 8'h01);
    chk("s1_dout", {7'd0, dout}, 8'h00);
    step(T01[0]);
    chk("valid_one_cycle", {7'd0, dibit_valid}, 8'h00);
    for (int i = 1; i < 8; i++) step(T01[i % 4]);
    chk("s2_dibit", {6'd0, dibit}, 8'h01);
    send_sym(T11, 8'h00);
    chk("s3_dibit", {6'd0, dibit}, 8'h03);
    send_sym(T10, 8'h00);
    chk("s4_dibit", {6'd0, dibit}, 8'h02);
    chk("s4_valid", {7'd0, dibit_valid}, 8'h01);
    chk("pulse_count", 8'(pulses), 8'd4);

    // Noise: one flip (t01=7), two flips (t01=6), constant 1 (all ties at 4)
    send_sym(T01, 8'b0000_0001);
    chk("flip1_dibit", {6'd0, dibit}, 8'h01);
    chk("flip1_err", {7'd0, sym_err}, 8'h00);
    send_sym(T01, 8'b0100_0010);
    chk("flip2_dibit", {6'd0, dibit}, 8'h01);
    chk("flip2_err", {7'd0, sym_err}, 8'h00);
    send_sym(4'b1111, 8'h00);
    chk("const1_dibit", {6'd0, dibit}, 8'h00);
    chk("const1_err", {7'd0, sym_err}, 8'h01);
    // Three flips: t01=t11=5, below threshold, 01 wins the tie
    fl = 8'b0110_0010;
    for (int i = 0; i < 4; i++) step(T01[i % 4] ^ fl[i]);
    chk("err_held", {7'd0, sym_err}, 8'h01);
    chk("err_held_dibit", {6'd0, dibit}, 8'h00);
    for (int i = 4; i < 8; i++) step(T01[i % 4] ^ fl[i]);
    chk("flip3_dibit", {6'd0, dibit}, 8'h01);
    chk("flip3_err", {7'd0, sym_err}, 8'h01);

    // Seamless serial stream for dibits 00,01,11,10
    seq = 8'b0001_1110;
    chk("log_len", 8'(dout_log.size() >= 32), 8'h01);
    for (int i = 0; i < 32; i++) begin
      if (i < dout_log.size()) chk($sformatf("stream_%0d", i), {7'd0, dout_log[i]}, {7'd0, seq[7 - i / 4]});
    end

    // Mid-symbol reset
    send_sym(T00, 8'h00);
    chk("pre_rst_err", {7'd0, sym_err}, 8'h00);
    for (int i = 0; i < 3; i++) step(T10[i % 4]);
    rst = 1'b1;
    step(T10[3]);
    chk("mid_rst_dibit", {6'd0, dibit}, 8'h00);
    chk("mid_rst_valid", {7'd0, dibit_valid}, 8'h00);
    chk("mid_rst_err", {7'd0, sym_err}, 8'h00);
    chk("mid_rst_dout", {7'd0, dout}, 8'h00);
    chk("mid_rst_dout_valid", {7'd0, dout_valid}, 8'h00);
    step(1'b0);
    step(1'b0);
    rst = 1'b0; log_en = 0; pulses = 0;
    for (int i = 0; i < 7; i++) step(T11[i % 4]);
    chk("post_rst_no_stale", 8'(pulses), 8'd0);
    chk("post_rst_dout_valid", {7'd0, dout_valid}, 8'h00);
    step(T11[3]);
    chk("post_rst_valid", {7'd0, dibit_valid}, 8'h01);
    chk("post_rst_dibit", {6'd0, dibit}, 8'h03);
    chk("post_rst_pulses", 8'(pulses), 8'd1);

    // Loopback with a behavioural modulator: bits 1,0,1,0,1,0
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    dout_log.delete();
    log_en = 1; err_seen = 0;
    x = 6'b101010;
    for (int j = 0; j < 3; j++) begin
      p = pat_of({x[5 - 2 * j], x[4 - 2 * j]});
      send_sym(p, 8'h00);
    end
    send_sym(T00, 8'h00);
    chk("loop_len", 8'(dout_log.size() >= 24), 8'h01);
    for (int j = 0; j < 6; j++) begin
      if (4 * j < dout_log.size()) chk($sformatf("loop_bit_%0d", j), {7'd0, dout_log[4 * j]}, {7'd0, x[5 - j]});
    end
    chk("loop_no_err", {7'd0, err_seen}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qpsk_demod.md
Name: qpsk_demod

Overview:
- Receive end of the 1-bit square-wave QPSK link produced by the `top` modulator.
- Samples the modulated stream `din` once per clk and correlates each symbol against the four reference carrier phases.
- Makes a maximum-match decision per symbol, recovers the Gray-coded dibit and re-serialises it to a bit stream (`dout`, MSB first).
- Sits directly after the modulator output, or after a channel model, in the qpsk loopback design.

Parameters:
- SYM_LEN, 8, clocks per symbol; must be a multiple of 4 (two carrier periods at default).
- MATCH_TH, 6, minimum winning match count; a symbol whose best count is below this is flagged in `sym_err`.
- ACC_W, $clog2(SYM_LEN+1), accumulator width (derived; do not override).

Ports:
- clk  in  1  system clock; one sample of `din` per rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  modulated QPSK square wave (carrier period 4 clk).
- dibit  out  2  last decided dibit, {first bit, second bit}.
- dibit_valid  out  1  one-cycle pulse when `dibit` / `sym_err` update.
- sym_err  out  1  set with a decision whose best match count is < MATCH_TH; held until the next decision.
- dout  out  1  recovered serial bit stream.
- dout_valid  out  1  high while `dout` carries recovered data.

Behaviour:
- Reset: clk and rst only; rst is synchronous, active-high. While rst=1 all counters, accumulators and outputs are 0 (dibit=00). The same applies when rst is asserted mid-operation: all state is lost and timing restarts from the release.
- Timing alignment: the demodulator and modulator are released from reset on the same clk edge. There is no carrier or symbol recovery in this block.
- Counters, both free-running from reset release:
  - ph, 0..3, carrier phase.
  - s, 0..SYM_LEN-1, sample index within the symbol. s wraps to 0 after SYM_LEN-1.
- Reference patterns, indexed by ph:
  - P00 = 1,1,0,0 (0°)
  - P01 = 0,1,1,0 (90°)
  - P11 = 0,0,1,1 (180°)
  - P10 = 1,0,0,1 (270°)
- Correlation: each cycle, m_k = (din == Pk[ph]) for each k, and acc_k <= acc_k + m_k.
- Decision, at the edge where s == SYM_LEN-1:
  - Totals are t_k = acc_k + m_k, so the final sample is included.
  - dibit <= argmax t_k. Ties are resolved by priority 00 > 01 > 11 > 10.
  - sym_err <= (max t_k < MATCH_TH).
  - dibit_valid <= 1 for exactly one cycle.
  - All acc_k <= 0 on the same edge, so no samples are lost between symbols.
- Latency: the first symbol occupies cycles 0..SYM_LEN-1 after release. dibit_valid is high in cycle SYM_LEN, and in every SYM_LEN cycles after that.
- Serializer:
  - On each decision, load the dibit.
  - dout = dibit[1] for SYM_LEN/2 cycles, then dibit[0] for SYM_LEN/2 cycles.
  - The next decision lands exactly as the previous symbol finishes, giving a seamless stream.
  - dout_valid goes 0→1 with the first dibit_valid and stays 1 until reset.
  - dout = 0 before the first decision.
- Error symbols: symbols with sym_err=1 are still serialised. sym_err does not affect dout_valid.
- Arithmetic: acc_k never exceeds SYM_LEN, so there is no overflow. All comparisons are unsigned.

Decomposition:
- Package qpsk_pkg:
  - CARR_PER = 4.
  - The four reference pattern constants.
  - The dibit Gray-map constants (00/01/11/10 ↔ phase index 0..3), shared with the modulator.
- Sub-module qpsk_corr: the four accumulators plus the argmax/tie-break/threshold logic. It exposes the decided dibit, an err flag and a done strobe.
- Top qpsk_demod: holds the ph/s counters and the serializer.

Test Plan:
1. Release rst at cycle 0; din = P00 repeated for 8 cycles → dibit_valid in cycle 8, dibit=00, sym_err=0; dout=0 in cycles 8–15; dout_valid=1 from cycle 8.
2. Symbols 00, 01, 11, 10 back-to-back (32 cycles) → dibits 00, 01, 11, 10 at cycles 8, 16, 24, 32; dout = 0,0,0,1,1,1,1,0, each bit held 4 cycles; no gaps.
3. Noise cases:
   - P01 with 1 sample flipped → t01=7, dibit=01, sym_err=0.
   - P01 with 2 flips → t01=6, dibit=01, sym_err=0.
   - din held at 1 for a symbol → all t=4, dibit=00 (tie priority), sym_err=1.
4. Assert rst at cycle 3 of the 2nd symbol → all outputs 0 on the next cycle. After release at cycle R, the first dibit_valid is at R+8 and no stale decision appears.
5. Loopback with the `top` modulator, serial input x = 1,0,1,0,1,0 → dout reproduces 1,0,1,0,1,0 at a fixed latency; sym_err never set.
